dds_wave_generator: RTL and testbench

Direct digital synthesis core that consumes the 12-bit frequency control word produced by the frequency-adjust logic and turns it into a continuous sine sample stream. It sits between the button-driven control-word source and the DAC/ADC-loopback path. It contains:
- a phase accumulator,
- a quarter-wave sine ROM lookup,
- a period-sync pulse.

---
 rtl/dds_wave_generator_pkg.sv | 36 +++
 rtl/dds_wave_generator_rom.sv | 18 +
 rtl/dds_wave_generator.sv | 85 ++++++++
 tb/tb_dds_wave_generator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dds_wave_generator_pkg.sv
// Shared constants, pipeline types and the quarter-wave sine table generator
// for the DDS wave generator.
package dds_wave_generator_pkg;

  localparam int         DDS_PHASE_W   = 10;
  localparam int         DDS_ROM_DEPTH = 256;
  localparam int         DDS_ROM_W     = 7;
  localparam logic [7:0] DDS_MIDSCALE  = 8'd128;

  typedef logic [DDS_ROM_DEPTH-1:0][DDS_ROM_W-1:0] rom_t;

  // Folded ROM address plus the sideband that travels with it.
  typedef struct packed {
    logic [7:0] addr;
    logic       neg;
    logic       wrap;
  } dds_s1_t;

  // M[i] = round(127 * sin(pi/2 * (i + 0.5) / 256)), evaluated at elaboration.
  function automatic rom_t sine_table();
    rom_t t;
    real  x, term, s;
    for (int i = 0; i < DDS_ROM_DEPTH; i++) begin
      x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(DDS_ROM_DEPTH);
      term = x;
      s    = x;
      for (int k = 1; k < 12; k++) begin
        term = -term * x * x / real'((2 * k) * (2 * k + 1));
        s    = s + term;
      end
      t[i] = DDS_ROM_W'($rtoi(127.0 * s + 0.5));
    end
    return t;
  endfunction

endpackage

// File: rtl/dds_wave_generator_rom.sv
// Quarter-wave sine magnitude ROM, 256 x 7, with a registered output.
module dds_sine_rom
  import dds_wave_generator_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [7:0]           addr,
  output logic [DDS_ROM_W-1:0] data
);

  localparam rom_t ROM = sine_table();

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) data <= '0;
    else       data <= ROM[addr];
  end

endmodule

// File: rtl/dds_wave_generator.sv
// DDS core: phase accumulator -> folded quarter-wave ROM -> offset-binary sine.
// Define DDS_KW_SYNC_EN to defer control-word changes to period boundaries.
module dds_wave_generator
  import dds_wave_generator_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [11:0]       KW_In,
  input  logic              Enable_In,
  output logic [DATA_W-1:0] Wave_Out,
  output logic              Sync_Out
);

  logic [ACC_W-1:0]       acc, kw_active;
  logic [ACC_W:0]         sum;
  logic                   wrap, acc_wrap;
  logic [DDS_PHASE_W-1:0] p;
  dds_s1_t                s1;
  logic                   s2_neg, s2_wrap;
  logic [DDS_ROM_W-1:0]   mag;

  assign sum  = {1'b0, acc} + {1'b0, kw_active};
  assign wrap = Enable_In & sum[ACC_W];
  assign p    = acc[ACC_W-1 -: DDS_PHASE_W];

  // S0: wrap is registered with the post-wrap phase so it stays aligned.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      acc      <= '0;
      acc_wrap <= 1'b0;
    end else begin
      if (Enable_In) acc <= sum[ACC_W-1:0];
      acc_wrap <= wrap;
    end
  end

`ifdef DDS_KW_SYNC_EN
  logic loaded;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      kw_active <= '0;
      loaded    <= 1'b0;
    end else if (Enable_In && (wrap || !loaded)) begin
      kw_active <= ACC_W'(KW_In);
      loaded    <= 1'b1;
    end
  end
`else
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) kw_active <= '0;
    else       kw_active <= ACC_W'(KW_In);
  end
`endif

  // S1 fold: odd quadrants read the table backwards (255 - idx == ~idx).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1       <= '0;
      s2_neg   <= 1'b0;
      s2_wrap  <= 1'b0;
      Wave_Out <= DDS_MIDSCALE;
      Sync_Out <= 1'b0;
    end else begin
      s1.addr  <= p[8] ? ~p[7:0] : p[7:0];
      s1.neg   <= p[9];
      s1.wrap  <= acc_wrap;
      s2_neg   <= s1.neg;
      s2_wrap  <= s1.wrap;
      Wave_Out <= s2_neg ? DDS_MIDSCALE - {1'b0, mag} : DDS_MIDSCALE + {1'b0, mag};
      Sync_Out <= s2_wrap;
    end
  end

  dds_sine_rom u_rom (
    .CLK  (CLK),
    .RSTn (RSTn),
    .addr (s1.addr),
    .data (mag)
  );

endmodule

// File: tb/tb_dds_wave_generator.sv
// Directed bench for dds_wave_generator: hand-computed sine samples, sync timing,
// enable freeze, control-word change and asynchronous reset.
module tb_dds_wave_generator;

  logic        CLK;
  logic        RSTn;
  logic [11:0] KW_In;
  logic        Enable_In;
  logic [7:0]  Wave_Out;
  logic        Sync_Out;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DDS_KW_SYNC_EN
  localparam int D_P64  = 68;
  localparam int D_P128 = 132;
`else
  localparam int D_P64  = 52;
  localparam int D_P128 = 84;
`endif

  dds_wave_generator #(.ACC_W(16), .DATA_W(8)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .KW_In     (KW_In),
    .Enable_In (Enable_In),
    .Wave_Out  (Wave_Out),
    .Sync_Out  (Sync_Out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [11:0] kw);
    @(negedge CLK);
    RSTn  = 1'b0;
    KW_In = kw;
    #1;
    chk("rst_wave", 0, Wave_Out, 8'd128);
    chk("rst_sync", 0, 8'(Sync_Out), 8'd0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  initial begin
    RSTn      = 1'b0;
    KW_In     = '0;
    Enable_In = 1'b1;

    // KW=0: phase never moves, output parked at midscale
    do_reset(12'd0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("kw0_wave", c, Wave_Out, 8'd128);
      chk("kw0_sync", c, 8'(Sync_Out), 8'd0);
    end

    // KW=1024: p steps 16 per cycle, sample k = 16k visible at cycle k+4
    do_reset(12'd1024);
    for (int c = 1; c <= 76; c++) begin
      tick();
      case (c)
        4, 36, 68: chk("k1024_wave", c, Wave_Out, 8'd128);
        5:         chk("k1024_wave", c, Wave_Out, 8'd141);
        8, 72:     chk("k1024_wave", c, Wave_Out, 8'd177);
        12, 28, 76: chk("k1024_wave", c, Wave_Out, 8'd218);
        16:        chk("k1024_wave", c, Wave_Out, 8'd245);
        20:        chk("k1024_wave", c, Wave_Out, 8'd255);
        40:        chk("k1024_wave", c, Wave_Out, 8'd79);
        44, 60:    chk("k1024_wave", c, Wave_Out, 8'd38);
        48:        chk("k1024_wave", c, Wave_Out, 8'd11);
        52:        chk("k1024_wave", c, Wave_Out, 8'd1);
        default: ;
      endcase
      chk("k1024_sync", c, 8'(Sync_Out), (c == 68) ? 8'd1 : 8'd0);
    end

    // Reset asserted mid-wave clears outputs without waiting for a clock
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("midrst_wave", 0, Wave_Out, 8'd128);
    chk("midrst_sync", 0, 8'(Sync_Out), 8'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c <= 4)  chk("post_rst_wave", c, Wave_Out, 8'd128);
      if (c == 5)  chk("post_rst_wave", c, Wave_Out, 8'd141);
      if (c == 12) chk("post_rst_wave", c, Wave_Out, 8'd218);
    end

    // KW=64: p steps 1 per cycle; enable low for 10 cycles holds p=16
    do_reset(12'd64);
    for (int c = 1; c <= 1040; c++) begin
      tick();
      if (c >= 20 && c <= 30) chk("freeze_wave", c, Wave_Out, 8'd141);
      case (c)
        31:       chk("resume_wave", c, Wave_Out, 8'd142);
        78:       chk("resume_wave", c, Wave_Out, 8'd177);
        142:      chk("resume_wave", c, Wave_Out, 8'd218);
        269, 270: chk("peak_wave", c, Wave_Out, 8'd255);
        1038:     chk("wrap_wave", c, Wave_Out, 8'd128);
        default: ;
      endcase
      chk("k64_sync", c, 8'(Sync_Out), (c == 1038) ? 8'd1 : 8'd0);
      if (c == 17) Enable_In = 1'b0;
      if (c == 27) Enable_In = 1'b1;
    end

    // Control word 64 -> 128 mid-period
    do_reset(12'd64);
    for (int c = 1; c <= 135; c++) begin
      tick();
      if (c == D_P64)  chk("kwchg_wave", c, Wave_Out, 8'd177);
      if (c == D_P128) chk("kwchg_wave", c, Wave_Out, 8'd218);
      if (c == 32) KW_In = 12'd128;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
